event_sched: RTL

EVENT_SCHED -- requirements
Module: event_sched

---
 rtl/event_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/event_sched.sv
// Event scheduler for a set of PHOLD cores: seeds an external min-queue,
// moves new events from cores into the queue, dispatches the queue head to
// idle cores within a lookahead window, and tracks global virtual time.
module event_sched #(
    parameter int NUM_CORES = 4,
    parameter int TIME_W    = 13,
    parameter int LP_W      = 3,
    parameter int WINDOW    = 16,
    parameter int END_TIME  = 8000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              q_enq,
    output logic                              q_deq,
    output logic [TIME_W+LP_W-1:0]            q_wdata,
    input  logic [TIME_W+LP_W-1:0]            q_rdata,
    input  logic [4:0]                        q_count,
    input  logic                              q_full,
    input  logic [NUM_CORES-1:0]              core_req,
    input  logic [NUM_CORES*(TIME_W+LP_W)-1:0] core_evt,
    output logic [NUM_CORES-1:0]              core_ack,
    input  logic [NUM_CORES-1:0]              core_ready,
    output logic [NUM_CORES-1:0]              core_dispatch,
    output logic [TIME_W+LP_W-1:0]            disp_data,
    output logic [TIME_W-1:0]                 gvt,
    output logic                              done
);

    localparam int EW = TIME_W + LP_W;
    localparam int PW = $clog2(NUM_CORES);
    localparam logic [TIME_W:0] END_T = (TIME_W+1)'(END_TIME);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LP_W-1:0]     init_k;
    logic [PW-1:0]       enq_ptr;
    logic [PW-1:0]       disp_ptr;
    logic [NUM_CORES-1:0] busy;
    logic [TIME_W-1:0]   ltime [NUM_CORES];

    logic                enq_found;
    logic [PW-1:0]       enq_win;
    logic                disp_found;
    logic [PW-1:0]       disp_win;
    logic [TIME_W-1:0]   head_time;
    logic                in_window;
    logic                enq_go;
    logic                deq_go;
    logic                gvt_has;
    logic [TIME_W-1:0]   gvt_cand;
    logic                gvt_over;
    logic                starved;

    assign head_time = q_rdata[EW-1:LP_W];
    // Window sum carries one extra bit so it never wraps below the head time
    assign in_window = {1'b0, head_time} <= ({1'b0, gvt} + (TIME_W+1)'(WINDOW));
    assign enq_go    = enq_found && !q_full;
    assign deq_go    = !enq_go && (q_count != '0) && disp_found && in_window;
    assign gvt_over  = {1'b0, gvt} > END_T;
    assign starved   = (busy == '0) && (q_count == '0) && (core_req == '0);

    // Round-robin search starting at each pointer; index arithmetic wraps at NUM_CORES
    always_comb begin
        enq_found  = 1'b0;
        enq_win    = '0;
        disp_found = 1'b0;
        disp_win   = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!enq_found && core_req[enq_ptr + PW'(i)]) begin
                enq_found = 1'b1;
                enq_win   = enq_ptr + PW'(i);
            end
            if (!disp_found && core_ready[disp_ptr + PW'(i)]) begin
                disp_found = 1'b1;
                disp_win   = disp_ptr + PW'(i);
            end
        end
    end

    // Minimum over busy-core local times and the queue head
    always_comb begin
        gvt_has  = 1'b0;
        gvt_cand = '1;
        if (q_count != '0) begin
            gvt_has  = 1'b1;
            gvt_cand = head_time;
        end
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (busy[i] && (!gvt_has || ltime[i] < gvt_cand)) begin
                gvt_has  = 1'b1;
                gvt_cand = ltime[i];
            end
        end
    end

    // Next-state and strobe outputs
    always_comb begin
        state_nxt     = state;
        q_enq         = 1'b0;
        q_deq         = 1'b0;
        q_wdata       = '0;
        core_ack      = '0;
        core_dispatch = '0;
        disp_data     = '0;
        done          = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_INIT;
            end
            S_INIT: begin
                q_enq   = 1'b1;
                q_wdata = {{TIME_W{1'b0}}, init_k};
                if (init_k == '1) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (enq_go) begin
                    q_enq             = 1'b1;
                    q_wdata           = core_evt[int'(enq_win)*EW +: EW];
                    core_ack[enq_win] = 1'b1;
                end else if (deq_go) begin
                    q_deq                   = 1'b1;
                    core_dispatch[disp_win] = 1'b1;
                    disp_data               = q_rdata;
                end
                if (gvt_over || starved) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Seed counter for the initial queue fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                init_k <= '0;
        else if (state == S_INIT)  init_k <= init_k + LP_W'(1);
        else if (state == S_IDLE)  init_k <= '0;
    end

    // Pointers, per-core busy/local time and gvt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gvt      <= '0;
            enq_ptr  <= '0;
            disp_ptr <= '0;
            busy     <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) ltime[i] <= '0;
        end else if (state == S_IDLE && start) begin
            gvt      <= '0;
            enq_ptr  <= '0;
            disp_ptr <= '0;
            busy     <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) ltime[i] <= '0;
        end else if (state == S_RUN) begin
            if (enq_go) begin
                busy[enq_win] <= 1'b0;
                enq_ptr       <= enq_win + PW'(1);
            end else if (deq_go) begin
                busy[disp_win]  <= 1'b1;
                ltime[disp_win] <= head_time;
                disp_ptr        <= disp_win + PW'(1);
            end
            if (gvt_has && gvt_cand >= gvt) gvt <= gvt_cand;
        end
    end

endmodule
